imem_loader: RTL

- Writer side of the instruction memory interface. The core only ever reads instruction memory through `pc`; this block is the path that fills it.
- Takes a byte stream from a host or boot source, assembles big-endian 32-bit words and writes them to consecutive word addresses.
- Holds the core in reset via core_hold until the program image is fully loaded.
- Word-addressed, matching the core's PC+1 word stepping.

---
 rtl/mips_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 33 +++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared instruction-memory geometry and loader state encoding
package mips_pkg;

    localparam int WORD_W      = 32;
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs bytes MSB-first into a 32-bit word
// o_word_full flags the shift that completes a word (4th byte).
module imem_loader_word_assembler
    import mips_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_full
);

    logic [1:0]        r_index;
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_index <= '0;
            r_word  <= '0;
        end else if (i_clear) begin
            r_index <= '0;
        end else if (i_shift) begin
            r_word  <= {r_word[WORD_W-9:0], i_byte};
            r_index <= r_index + 2'd1;
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_shift && (r_index == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader, holds the core until loaded
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_wdata,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t S_AFTER_LAST = S_CHK;
`else
    localparam loader_state_t S_AFTER_LAST = S_DONE;
`endif

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [15:0]       w_len;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_word_full;
    logic              w_count_last;
    logic              w_len_zero;
    logic              w_len_over;
    logic              w_csum_ok;
    logic [WORD_W-1:0] w_word;

    assign w_len        = {r_len_hi, i_byte_data};
    assign w_len_zero   = (w_len == 16'd0);
    assign w_len_over   = ({1'b0, w_len} > DEPTH_L);
    assign w_count_last = ((r_count + 16'd1) == r_len);
    assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                      (r_state == S_ERR));
    assign w_xfer       = i_byte_valid && o_byte_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if ((r_state == S_DATA) && w_xfer) begin
            r_csum <= r_csum ^ i_byte_data;
        end
    end

    assign w_csum_ok = (i_byte_data == r_csum);
`else
    assign w_csum_ok = 1'b0;
`endif

    imem_loader_word_assembler u_word_assembler (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_clear     (w_start_ok),
        .i_shift     ((r_state == S_DATA) && w_xfer),
        .i_byte      (i_byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_count  <= '0;
        end else begin
            if (w_start_ok) begin
                r_count <= '0;
            end else if (r_state == S_WRITE) begin
                r_count <= r_count + 16'd1;
            end
            if ((r_state == S_LEN_HI) && w_xfer) begin
                r_len_hi <= i_byte_data;
            end
            if ((r_state == S_LEN_LO) && w_xfer) begin
                r_len <= w_len;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    w_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_zero) begin
                        w_next = S_AFTER_LAST;
                    end else if (w_len_over) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_full) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_count_last ? S_AFTER_LAST : S_DATA;
            end
            S_CHK: begin
                if (w_xfer) begin
                    w_next = w_csum_ok ? S_DONE : S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // core_hold drops only in DONE and rises again combinationally with an accepted start
    always_comb begin
        o_byte_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CHK);
        o_imem_we    = (r_state == S_WRITE);
        o_imem_addr  = r_count[ADDR_W-1:0];
        o_imem_wdata = w_word;
        o_done       = (r_state == S_DONE);
        o_error      = (r_state == S_ERR);
        o_core_hold  = !((r_state == S_DONE) && !i_start);
    end

endmodule
